// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port between NREQ writeback sources
//   (ALU, load unit, multiply unit) using round-robin arbitration. The winning
//   request is captured into a registered output stage that drives the RF.
//   The RF writes on the falling edge after the capturing rising edge.
//
//   Optional feature macro: RF_WB_SCOREBOARD_EN
//     When defined, a busy-bit scoreboard tracks registers with an outstanding
//     writeback. It raises hazard so decode can stall on those registers. It
//     also flags a writeback to a register that was never marked busy on the
//     sticky wb_err output. When undefined, hazard and wb_err are tied low and
//     the issue/operand inputs are ignored.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; transfer when both are high
//   req_addr/data     packed per-requester destination and data
//   writeaddress,
//   writeData, isWb   registered RF write port (isWb low for register 0)
//   issue_valid/rd    decode issues an instruction that writes issue_rd
//   rs1, rs2          source operands of the instruction in decode
//   hazard            an operand or the destination is busy (combinational)
//   wb_err            sticky: writeback to a non-busy register
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 4,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [AW-1:0]        writeaddress,
    output logic [DW-1:0]        writeData,
    output logic                 isWb,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 hazard,
    output logic                 wb_err
);

    localparam int PW   = $clog2(NREQ);
    localparam int NREG = 2 ** AW;

    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   gidx_s;
    logic            found_s;
    logic [NREQ-1:0] grant_s;
    logic            transfer_s;
    logic [AW-1:0]   addr_sel_s;
    logic [DW-1:0]   data_sel_s;

    // Round-robin search: walk from the highest offset down so the requester
    // closest after the pointer is the last one written and therefore wins.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                gidx_s  = PW'((int'(ptr_r) + k) % NREQ);
            end else begin
                found_s = found_s;
                gidx_s  = gidx_s;
            end
        end
    end

    // One-hot grant vector and AND-OR mux of the winning address and data.
    always_comb begin
        grant_s    = '0;
        addr_sel_s = '0;
        data_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i] = found_s && (gidx_s == PW'(i));
            addr_sel_s = addr_sel_s | (req_addr[i*AW +: AW] & {AW{grant_s[i]}});
            data_sel_s = data_sel_s | (req_data[i*DW +: DW] & {DW{grant_s[i]}});
        end
    end

    // Grants are suppressed while reset is high, so nothing is accepted and then lost.
    assign req_ready  = reset ? '0 : grant_s;
    assign transfer_s = |req_ready;

    // Output stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r        <= PW'(NREQ - 1);
            writeaddress <= '0;
            writeData    <= '0;
            isWb         <= 1'b0;
        end else if (transfer_s) begin
            ptr_r        <= gidx_s;
            writeaddress <= addr_sel_s;
            writeData    <= data_sel_s;
            isWb         <= (addr_sel_s != '0);
        end else begin
            isWb         <= 1'b0;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_n_s;
    logic            set_s;
    logic            err_set_s;
    logic            wb_err_r;

    assign set_s = issue_valid && (issue_rd != '0);

    // Next busy vector: a clear from an accepted writeback is applied before
    // the set from issue, so a same-edge set on the same register wins.
    always_comb begin
        busy_n_s = busy_r;
        if (transfer_s) begin
            busy_n_s[addr_sel_s] = 1'b0;
        end else begin
            busy_n_s = busy_n_s;
        end
        if (set_s) begin
            busy_n_s[issue_rd] = 1'b1;
        end else begin
            busy_n_s = busy_n_s;
        end
        busy_n_s[0] = 1'b0;
    end

    assign err_set_s = transfer_s && (addr_sel_s != '0) && !busy_r[addr_sel_s]
                       && !(set_s && (issue_rd == addr_sel_s));

    // Scoreboard state and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= '0;
            wb_err_r <= 1'b0;
        end else begin
            busy_r   <= busy_n_s;
            wb_err_r <= wb_err_r | err_set_s;
        end
    end

    assign hazard = busy_r[rs1] | busy_r[rs2] | (issue_valid & busy_r[issue_rd]);
    assign wb_err = wb_err_r;
`else
    logic unused_issue_s;
    assign unused_issue_s = ^{issue_valid, issue_rd, rs1, rs2, NREG[0]};
    assign hazard = 1'b0;
    assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Self-checking bench for rf_wb_arbiter (NREQ=3, AW=4, DW=32). A reference
//   model built from the arbitration and scoreboard rules is compared with the
//   DUT on every falling edge. Directed sequences add hand-computed literal
//   expectations that pin the model itself. A small RF array written on the
//   falling edge stands in for the register file.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [AW-1:0]        writeaddress;
    logic [DW-1:0]        writeData;
    logic                 isWb;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 hazard;
    logic                 wb_err;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .writeaddress(writeaddress), .writeData(writeData), .isWb(isWb),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .hazard(hazard), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file model, written on the falling edge.
    logic [DW-1:0] rf [16];
    initial for (int i = 0; i < 16; i++) rf[i] = '0;
    always @(negedge clk) if (isWb) rf[writeaddress] = writeData;

    // Reference model state.
    int            last_m;
    logic [AW-1:0] wa_m;
    logic [DW-1:0] wd_m;
    logic          iswb_m;
    logic          busy_m [16];
    logic          err_m;
    int            g_m;
    logic [AW-1:0] a_m;

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
        end
        return -1;
    endfunction

    // Model update at each rising edge (inputs change 1ns after the edge).
    always @(posedge clk) begin
        if (reset) begin
            last_m = NREQ - 1; wa_m = '0; wd_m = '0; iswb_m = 1'b0; err_m = 1'b0;
            for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
        end else begin
            g_m = pick();
            if (g_m >= 0) begin
                a_m    = req_addr[g_m*AW +: AW];
                wa_m   = a_m;
                wd_m   = req_data[g_m*DW +: DW];
                iswb_m = (a_m != 0);
                last_m = g_m;
`ifdef RF_WB_SCOREBOARD_EN
                if (a_m != 0 && !busy_m[a_m] && !(issue_valid && issue_rd == a_m)) err_m = 1'b1;
                busy_m[a_m] = 1'b0;
`endif
            end else begin
                iswb_m = 1'b0;
            end
`ifdef RF_WB_SCOREBOARD_EN
            if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
`endif
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        logic            eh;
        int              p;
        er = '0;
        p  = pick();
        if (!reset && p >= 0) er[p] = 1'b1;
`ifdef RF_WB_SCOREBOARD_EN
        eh = busy_m[rs1] | busy_m[rs2] | (issue_valid & busy_m[issue_rd]);
`else
        eh = 1'b0;
`endif
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_isWb", 64'(isWb), 64'(iswb_m));
        chk("m_waddr", 64'(writeaddress), 64'(wa_m));
        chk("m_wdata", 64'(writeData), 64'(wd_m));
        chk("m_hazard", 64'(hazard), 64'(eh));
        chk("m_wb_err", 64'(wb_err), 64'(err_m));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    logic [1:0]    t1_g [4];
    logic [AW-1:0] t1_a [4];

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        t1_g = '{2'd0, 2'd1, 2'd2, 2'd0};
        t1_a = '{4'd1, 4'd2, 4'd3, 4'd1};
        step(); step();
        chk("rst_isWb", 64'(isWb), 64'd0);
        chk("rst_waddr", 64'(writeaddress), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        reset = 1'b0;

        // 1: all three valid, rotating grants 0,1,2,0.
        set_req(0, 4'd1, 32'h1111_0001);
        set_req(1, 4'd2, 32'h2222_0002);
        set_req(2, 4'd3, 32'h3333_0003);
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t1_ready", 64'(req_ready), 64'(3'b001 << t1_g[n]));
            step();
            chk("t1_isWb", 64'(isWb), 64'd1);
            chk("t1_waddr", 64'(writeaddress), 64'(t1_a[n]));
        end
        req_valid = '0;
        step();
        chk("t1_idle_isWb", 64'(isWb), 64'd0);
        chk("t1_hold_waddr", 64'(writeaddress), 64'd1);

        // 2: lone requester 2.
        set_req(2, 4'd5, 32'hDEAD_BEEF);
        req_valid = 3'b100;
        @(negedge clk);
        chk("t2_ready", 64'(req_ready), 64'(3'b100));
        step();
        req_valid = '0;
        chk("t2_isWb", 64'(isWb), 64'd1);
        chk("t2_waddr", 64'(writeaddress), 64'd5);
        chk("t2_wdata", 64'(writeData), 64'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("t2_rf5", 64'(rf[5]), 64'hDEAD_BEEF);

        // 3: write to register 0 completes without enabling the RF.
        set_req(0, 4'd0, 32'h0000_1234);
        req_valid = 3'b001;
        step();
        @(negedge clk);
        chk("t3_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        chk("t3_isWb", 64'(isWb), 64'd0);
        chk("t3_wdata", 64'(writeData), 64'h1234);
        @(negedge clk); #1;
        chk("t3_rf0", 64'(rf[0]), 64'd0);
        step();

`ifdef RF_WB_SCOREBOARD_EN
        // 4: hazard on a busy register, cleared by its writeback.
        issue_valid = 1'b1; issue_rd = 4'd7;
        step();
        issue_valid = 1'b0; rs1 = 4'd7;
        @(negedge clk);
        chk("t4_hazard_set", 64'(hazard), 64'd1);
        step();
        set_req(1, 4'd7, 32'h0000_0077);
        req_valid = 3'b010;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t4_hazard_clr", 64'(hazard), 64'd0);
        step();
        issue_valid = 1'b1; issue_rd = 4'd7; req_valid = 3'b010;
        step();
        issue_valid = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t4_set_wins", 64'(hazard), 64'd1);
        chk("t4_no_err", 64'(wb_err), 64'd0);
        step();
        req_valid = 3'b010;
        step();
        req_valid = '0; rs1 = '0;
        step();

        // 5: writeback to a register never issued.
        set_req(0, 4'd9, 32'h0000_0099);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        chk("t5_err", 64'(wb_err), 64'd1);
        step(); step();
        chk("t5_err_held", 64'(wb_err), 64'd1);
`endif

        // 6: one-cycle reset with all requesters valid.
        set_req(0, 4'd1, 32'hA0);
        set_req(1, 4'd2, 32'hA1);
        set_req(2, 4'd3, 32'hA2);
        req_valid = 3'b111;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ready_rst", 64'(req_ready), 64'd0);
        step();
        reset = 1'b0;
        chk("t6_isWb_rst", 64'(isWb), 64'd0);
        chk("t6_err_rst", 64'(wb_err), 64'd0);
        @(negedge clk);
        chk("t6_first_grant", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        chk("t6_waddr", 64'(writeaddress), 64'd1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
